// File: rtl/snow3g_f8_xor.sv
// SNOW 3G f8 keystream consumer: sequences generator init, buffers keystream, XORs onto data.
// Define SNOW3G_F8_MASK_EN to zero the unused trailing bits of the final word.
module snow3g_f8_xor #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INIT_CYCLES = 32,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             gen_en,
    output logic             gen_init,
    input  logic [31:0]      ks_in,
    input  logic [31:0]      din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [31:0]      dout_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = LEN_W - 4;
    localparam int CW = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_DISCARD,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_init_cnt;
    logic [NW-1:0]   r_nwords;
    logic [NW-1:0]   r_fetched;
    logic [NW-1:0]   r_emitted;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [31:0]     r_dout_data;
    logic            r_dout_valid;
    logic            r_dout_last;
    logic            r_gen_init;
    logic            r_busy;
    logic            r_done;
`ifdef SNOW3G_F8_MASK_EN
    logic [4:0]      r_rem;
`endif

    logic            w_empty;
    logic            w_full;
    logic            w_gen_en;
    logic            w_din_ready;
    logic            w_push;
    logic            w_din_hs;
    logic            w_dout_hs;
    logic            w_is_last;
    logic [NW-1:0]   w_nwords;
    logic [31:0]     w_xor;
    logic [31:0]     w_out;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_nwords  = NW'(msg_len[LEN_W-1:5]) + NW'(|msg_len[4:0]);
    assign w_is_last = (r_emitted == r_nwords - NW'(1));
    assign w_xor     = din_data ^ r_mem[r_rd_ptr[AW-1:0]];

`ifdef SNOW3G_F8_MASK_EN
    assign w_out = (w_is_last && r_rem != 5'd0) ? (w_xor & ~(32'hFFFF_FFFF >> r_rem)) : w_xor;
`else
    assign w_out = w_xor;
`endif

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_gen_en = 1'b0;
        case (r_state)
            S_INIT, S_DISCARD: w_gen_en = 1'b1;
            S_RUN:             w_gen_en = !w_full && (r_fetched < r_nwords);
            default:           w_gen_en = 1'b0;
        endcase
    end

    assign w_din_ready = (r_state == S_RUN) && !w_empty &&
                         (!r_dout_valid || dout_ready) && (r_emitted < r_nwords);
    assign w_push      = (r_state == S_RUN) && w_gen_en;
    assign w_din_hs    = din_valid && w_din_ready;
    assign w_dout_hs   = r_dout_valid && dout_ready;

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= ks_in;
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_init_cnt   <= '0;
            r_nwords     <= '0;
            r_fetched    <= '0;
            r_emitted    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_dout_data  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_gen_init   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef SNOW3G_F8_MASK_EN
            r_rem        <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_fetched <= r_fetched + NW'(1);
            end
            if (w_din_hs) begin
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                r_emitted    <= r_emitted + NW'(1);
                r_dout_data  <= w_out;
                r_dout_valid <= 1'b1;
                r_dout_last  <= w_is_last;
            end else if (w_dout_hs) begin
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nwords <= w_nwords;
`ifdef SNOW3G_F8_MASK_EN
                        r_rem    <= msg_len[4:0];
`endif
                        if (w_nwords == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= S_INIT;
                            r_gen_init <= 1'b1;
                            r_busy     <= 1'b1;
                            r_init_cnt <= CW'(INIT_CYCLES - 1);
                            r_fetched  <= '0;
                            r_emitted  <= '0;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                        end
                    end
                end
                S_INIT: begin
                    if (r_init_cnt == '0) begin
                        r_state    <= S_DISCARD;
                        r_gen_init <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt - CW'(1);
                    end
                end
                S_DISCARD: r_state <= S_RUN;
                S_RUN: begin
                    if (w_dout_hs && r_dout_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gen_en     = w_gen_en;
    assign gen_init   = r_gen_init;
    assign din_ready  = w_din_ready;
    assign dout_data  = r_dout_data;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_snow3g_f8_xor.sv
// Self-checking bench for snow3g_f8_xor: directed and random messages vs a word-level keystream model.
module tb_snow3g_f8_xor;

    localparam int FIFO_DEPTH  = 4;
    localparam int INIT_CYCLES = 32;
    localparam int LEN_W       = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             gen_en;
    logic             gen_init;
    logic [31:0]      ks_in;
    logic [31:0]      din_data;
    logic             din_valid;
    logic             din_ready;
    logic [31:0]      dout_data;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             busy;
    logic             done;

    int          n_cmp;
    int          n_fail;
    int          edge_cnt;
    int          start_edge;
    int          ks_idx;
    logic [31:0] ks_arr [64];

    snow3g_f8_xor #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .INIT_CYCLES(INIT_CYCLES),
        .LEN_W      (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .msg_len   (msg_len),
        .gen_en    (gen_en),
        .gen_init  (gen_init),
        .ks_in     (ks_in),
        .din_data  (din_data),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout_data (dout_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Generator model: the keystream sequence advances on every post-init step.
    assign ks_in = ks_arr[ks_idx[5:0]];
    always begin : gen_model
        bit adv;
        @(negedge clk);
        adv = gen_en && !gen_init;
        @(posedge clk);
        #1;
        if (adv && rst_n) ks_idx++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " dout_valid"}, dout_valid, 0);
        check({tag, " dout_last"},  dout_last,  0);
        check({tag, " dout_data"},  dout_data,  0);
        check({tag, " busy"},       busy,       0);
        check({tag, " done"},       done,       0);
        check({tag, " gen_en"},     gen_en,     0);
        check({tag, " gen_init"},   gen_init,   0);
        check({tag, " din_ready"},  din_ready,  0);
    endtask

    // ks_mode/din_mode: 0 counter/all-ones, 1 A5 pattern/zero, 2 random.
    // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random.
    task automatic run_msg(input string tag, input int len, input int ks_mode, input int din_mode,
                           input int rdy_mode, input bit v_rand, input bit chk_lat,
                           input int restart_word, input int abort_word);
        logic [31:0] din_arr [64];
        logic [31:0] exp_q [$];
        logic [31:0] w;
        int n, r, sent, recv, cyc, dones, init_cyc, gen_cnt, busy_cnt, lat, extra, occ;
        bit first_seen, restarted, aborted;
        n = (len + 31) / 32;
        r = len % 32;
        sent = 0; recv = 0; cyc = 0; dones = 0; init_cyc = 0; gen_cnt = 0;
        busy_cnt = 0; lat = -1; extra = 0;
        first_seen = 0; restarted = 0; aborted = 0;
        for (int k = 0; k < 64; k++) begin
            case (ks_mode)
                0:       ks_arr[k] = 32'(k + 1);
                1:       ks_arr[k] = 32'hA5A5_A5A5;
                default: ks_arr[k] = $urandom;
            endcase
        end
        for (int i = 0; i < 64; i++) begin
            case (din_mode)
                0:       din_arr[i] = 32'hFFFF_FFFF;
                1:       din_arr[i] = 32'h0;
                default: din_arr[i] = $urandom;
            endcase
        end
        // Word i uses keystream word i+1; word 0 belongs to the discarded step.
        for (int i = 0; i < n; i++) begin
            w = din_arr[i] ^ ks_arr[i + 1];
`ifdef SNOW3G_F8_MASK_EN
            if (i == n - 1 && r != 0) w = (w >> (32 - r)) << (32 - r);
`endif
            exp_q.push_back(w);
        end

        @(posedge clk);
        #1;
        while (cyc < 3000) begin
            if (cyc == 0) begin
                ks_idx     = 0;
                start      = 1'b1;
                msg_len    = LEN_W'(len);
                start_edge = edge_cnt + 1;
            end else if (restart_word > 0 && !restarted && recv == restart_word) begin
                start     = 1'b1;
                msg_len   = LEN_W'(32);
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            din_valid = (sent < n) && (!v_rand || $urandom_range(0, 1) == 1);
            din_data  = (sent < n) ? din_arr[sent] : $urandom;
            case (rdy_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (cyc % 3 == 0);
                default: dout_ready = ($urandom_range(0, 1) == 1);
            endcase

            @(negedge clk);
            if (gen_init) init_cyc++;
            if (gen_en)   gen_cnt++;
            if (busy)     busy_cnt++;
            if (ks_idx > 0) begin
                occ = ks_idx - 1 - sent;
                check({tag, " fifo_occupancy_in_range"}, (occ >= 0 && occ <= FIFO_DEPTH), 1);
            end
            if (din_valid && din_ready) sent++;
            if (dout_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    lat = edge_cnt - start_edge;
                end
                check({tag, " word_within_length"}, (recv < n), 1);
                if (recv < n) begin
                    check({tag, " dout_data"}, dout_data, exp_q[recv]);
                    check({tag, " dout_last"}, dout_last, (recv == n - 1));
                end
                if (dout_ready) recv++;
            end
            if (done) begin
                dones++;
                check({tag, " busy_low_with_done"}, busy, 0);
                check({tag, " dout_valid_low_with_done"}, dout_valid, 0);
                break;
            end
            if (abort_word > 0 && recv == abort_word) begin
                #1 rst_n = 1'b0;
                #1 check_quiet({tag, " in_reset"});
                aborted = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        start     = 1'b0;
        din_valid = 1'b0;
        if (aborted) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_quiet({tag, " after_reset"});
            return;
        end
        check({tag, " done_seen_in_budget"}, dones, 1);
        check({tag, " words_received"}, recv, n);
        if (n > 0) begin
            check({tag, " init_cycles"}, init_cyc, INIT_CYCLES);
            check({tag, " generator_steps"}, ks_idx, n + 1);
        end else begin
            check({tag, " gen_en_untouched"}, gen_cnt, 0);
            check({tag, " busy_untouched"}, busy_cnt, 0);
        end
        if (chk_lat) check({tag, " first_dout_latency"}, lat, INIT_CYCLES + 3);
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({tag, " single_done"}, extra, 0);
        check({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        edge_cnt   = 0;
        ks_idx     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        msg_len    = '0;
        din_data   = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        for (int k = 0; k < 64; k++) ks_arr[k] = '0;

        #12 check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        run_msg("zero_len",  0,   0, 0, 0, 0, 0, 0, 0);
        run_msg("len96",     96,  0, 0, 0, 0, 1, 0, 0);
        run_msg("len40",     40,  1, 1, 0, 0, 1, 0, 0);
        run_msg("len32",     32,  2, 2, 0, 0, 1, 0, 0);
        run_msg("bp320",     320, 2, 2, 1, 0, 0, 0, 0);
        run_msg("restart",   160, 2, 2, 0, 0, 1, 2, 0);
        run_msg("abort",     160, 2, 2, 0, 0, 0, 0, 2);
        run_msg("after_rst", 32,  2, 2, 0, 0, 1, 0, 0);
        for (int t = 0; t < 4; t++) begin
            run_msg("random", int'($urandom_range(1, 400)), 2, 2, 2, 1, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snow3g_f8_xor.md
# snow3g_f8_xor

Downstream keystream consumer for the SNOW 3G generator. It sequences the generator through its initialisation phase, discards the first post-init word, and buffers keystream words in a small FIFO. It XORs those words onto an incoming 32-bit data stream to produce f8-style ciphertext/plaintext with a valid/ready handshake on both sides. The block drives the generator's clock-enable and init-mode strobes and consumes its 32-bit `keystream` output.

## Interface
- `FIFO_DEPTH`, 4, keystream FIFO depth in words; power of two, ≥2
- `INIT_CYCLES`, 32, generator clocks in init mode before keystream mode
- `LEN_W`, 16, width of message length field in bits

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `start`  in  1  begin message; sampled only in IDLE
- `msg_len`  in  LEN_W  message length in bits, captured on accepted `start`
- `gen_en`  out  1  generator advances one step at the next edge when high
- `gen_init`  out  1  generator in init mode (output fed back, not emitted)
- `ks_in`  in  32  generator keystream word, valid in any cycle with `gen_en`=1 and `gen_init`=0
- `din_data`  in  32  input data word, MSB = first bit
- `din_valid`  in  1  input word valid
- `din_ready`  out  1  input word accepted when `din_valid`&&`din_ready`
- `dout_data`  out  32  `din_data` ^ keystream (masked on last word)
- `dout_valid`  out  1  output word valid
- `dout_ready`  in  1  downstream accepts
- `dout_last`  out  1  marks final word of message
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse when message completes

## Operation
- States: IDLE → INIT → DISCARD → RUN → IDLE.
- IDLE: `start`=1 captures `msg_len` and computes `nwords` = ceil(msg_len/32) (LEN_W-5+1 bits). If `nwords`=0, the block pulses `done` the next cycle and stays in IDLE; the generator is not touched.
- INIT: `gen_en`=1, `gen_init`=1 for exactly INIT_CYCLES cycles (down-counter), then DISCARD.
- DISCARD: one cycle, `gen_en`=1, `gen_init`=0; `ks_in` ignored; then RUN.
- RUN, fetch side: `gen_en` = !fifo_full && (fetched < nwords). Each fetch cycle pushes `ks_in`.
- RUN, data side: `din_ready` = fifo nonempty && (!`dout_valid` || `dout_ready`) && (emitted < nwords).
- On a din handshake, the FIFO pops, the output register loads `din_data` ^ head, `dout_valid`←1, and `dout_last`←(emitted == nwords-1).
- Output holds stable while `dout_valid` && !`dout_ready`. Simultaneous pop and push on the FIFO is legal; occupancy is unchanged.
- Last-word masking: r = msg_len[4:0]. For r≠0, `dout_data[31-r:0]` are forced to 0; for r=0 the full word is used.
- Completion: the handshake on the word with `dout_last`=1 pulses `done` and returns to IDLE. The FIFO is empty at that point by construction.
- `start` outside IDLE is ignored; `msg_len` is not re-sampled.
- `rst_n` low at any time, including mid-message: immediate return to IDLE, FIFO pointers and counters cleared, in-flight words dropped.
- Reset values: `gen_en`=0, `gen_init`=0, `din_ready`=0, `dout_data`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0.

## Timing
- Edge E0 samples `start`. INIT spans E1..E(INIT_CYCLES), DISCARD ends at E(INIT_CYCLES+1), the first `ks_in` push is at E(INIT_CYCLES+2), and the earliest `din_ready` follows that push.
- Earliest `dout_valid` occurs after E(INIT_CYCLES+3), i.e. 35 edges after `start` at default.
- Steady state with `din_valid`=`dout_ready`=1 constantly: one word per cycle.
- Output-register latency: 1 cycle from din handshake to `dout_valid`.
- `done` is asserted in the cycle after the final dout handshake; `busy` falls in the same cycle.
- All outputs are registered except `din_ready` and `gen_en`, which are combinational from state, FIFO flags and `dout_ready`.

## Configuration
- `SNOW3G_F8_MASK_EN` defined: last-word trailing-bit masking as above.
- Not defined: no masking; `dout_data` is the full 32-bit XOR on every word, including the last. Length still determines word count and `dout_last`.

## Test plan
- Reset then idle: all outputs 0; `start`=1 with `msg_len`=0 → `done` pulse next cycle, `gen_en` never high, `busy` stays 0.
- `msg_len`=96, `ks_in` counter model (0x1,0x2,…), `din_data`=0xFFFFFFFF, free-flowing → `gen_init` high exactly 32 cycles, word fetched at DISCARD dropped, 3 outputs = ~ks values in order, `dout_last` on the 3rd, first `dout_valid` 35 edges after `start`.
- `msg_len`=40, `din_data`=0, ks=0xA5A5A5A5 → 2 words: 0xA5A5A5A5, then 0xA5000000 with mask enabled (0xA5A5A5A5 without).
- Backpressure: `dout_ready` toggling 1-in-3, `msg_len`=320 → `dout_data` stable while stalled, FIFO never overflows (`gen_en`=0 when full), 10 words correct, single `done`.
- `start` pulsed again mid-RUN with `msg_len`=32 → ignored; original length completes.
- `rst_n` asserted during RUN after 2 of 5 words → outputs 0 immediately; new `start` with `msg_len`=32 runs full INIT and produces exactly 1 word.
